// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with 2-bit saturating direction counters. The table is
//   looked up combinationally with the fetch PC. The prediction then rides the
//   D and E pipeline registers and is resolved in Execute against the actual
//   branch outcome.
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   PCF                   fetch PC
//   PredTakenF/TargetF    fetch-stage prediction (target is 0 on a miss)
//   StallD, FlushD        D prediction register hold / clear (flush wins)
//   FlushE                E prediction register clear
//   BranchE               branch in E; the only qualifier for table writes
//   BranchTakenActualE    actual direction of the branch in E
//   BranchTargetE         actual target of the branch in E
//   CorrectPredE          E prediction was taken with the exact target
//   RecoverE              E predicted taken but was not taken; redirect
//   RecoverPCE            PCE + 4, the fall-through redirect address
// ---------------------------------------------------------------------------

// One BTB entry. Owns its valid/tag/target/counter state. It applies an update
// when selected by the E-stage index.
module branch_predictor_entry #(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_upd,
  input  logic             i_taken,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [31:0]      i_target,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_target,
  output logic             o_dir
);
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_target;
  logic [1:0]       r_ctr;
  logic             w_hit;

  assign w_hit = r_valid & (r_tag == i_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= 2'b00;
    end else if (i_upd) begin
      if (i_taken) begin
        if (w_hit) begin
          if (r_ctr != 2'b11) r_ctr <= r_ctr + 2'd1;
          r_target <= i_target;
        end else begin
          // Allocate over whatever was here, starting weakly taken.
          r_valid  <= 1'b1;
          r_tag    <= i_tag;
          r_target <= i_target;
          r_ctr    <= 2'b10;
        end
      end else if (w_hit && r_ctr != 2'b00) begin
        r_ctr <= r_ctr - 2'd1;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_target = r_target;
  assign o_dir    = r_ctr[1];
endmodule

module branch_predictor #(
  parameter int ENTRIES = 16  // power of 2, >= 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BranchE,
  input  logic        BranchTakenActualE,
  input  logic [31:0] BranchTargetE,
  output logic        CorrectPredE,
  output logic        RecoverE,
  output logic [31:0] RecoverPCE
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Table read-out, one slot per entry.
  logic [ENTRIES-1:0]            w_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] w_tag;
  logic [ENTRIES-1:0][31:0]      w_target;
  logic [ENTRIES-1:0]            w_dir;

  logic [IDX_W-1:0] w_idx_f, w_idx_e;
  logic [TAG_W-1:0] w_tag_f, w_tag_e;
  logic             w_hit_f;

  // D / E prediction pipeline registers.
  logic        r_pred_taken_d, r_pred_taken_e;
  logic [31:0] r_pred_target_d, r_pred_target_e;
  logic [31:0] r_pc_d, r_pc_e;

  assign w_idx_f = PCF[IDX_W+1:2];
  assign w_tag_f = PCF[31:IDX_W+2];
  assign w_idx_e = r_pc_e[IDX_W+1:2];
  assign w_tag_e = r_pc_e[31:IDX_W+2];

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_entry
      branch_predictor_entry #(.TAG_W(TAG_W)) u_entry (
        .clk      (clk),
        .reset    (reset),
        .i_upd    (BranchE && (w_idx_e == IDX_W'(g))),
        .i_taken  (BranchTakenActualE),
        .i_tag    (w_tag_e),
        .i_target (BranchTargetE),
        .o_valid  (w_valid[g]),
        .o_tag    (w_tag[g]),
        .o_target (w_target[g]),
        .o_dir    (w_dir[g])
      );
    end
  endgenerate

  // Fetch lookup sees registered table state, so a same-cycle update to the
  // same index shows up only on the following cycle.
  assign w_hit_f     = w_valid[w_idx_f] & (w_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f & w_dir[w_idx_f];
  assign PredTargetF = w_hit_f ? w_target[w_idx_f] : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
      r_pc_d          <= '0;
    end else if (FlushD) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
      r_pc_d          <= '0;
    end else if (!StallD) begin
      r_pred_taken_d  <= PredTakenF;
      r_pred_target_d <= PredTargetF;
      r_pc_d          <= PCF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= '0;
      r_pc_e          <= '0;
    end else if (FlushE) begin
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= '0;
      r_pc_e          <= '0;
    end else begin
      r_pred_taken_e  <= r_pred_taken_d;
      r_pred_target_e <= r_pred_target_d;
      r_pc_e          <= r_pc_d;
    end
  end

  // A taken prediction with the wrong target raises neither output. The
  // controller's own BranchTakenE redirect handles that case.
  assign CorrectPredE = r_pred_taken_e & BranchTakenActualE &
                        (r_pred_target_e == BranchTargetE);
  assign RecoverE     = r_pred_taken_e & ~BranchTakenActualE;
  assign RecoverPCE   = r_pc_e + 32'd4;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        StallD, FlushD, FlushE;
  logic        BranchE, BranchTakenActualE;
  logic [31:0] BranchTargetE;
  logic        CorrectPredE, RecoverE;
  logic [31:0] RecoverPCE;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .BranchE(BranchE),
    .BranchTakenActualE(BranchTakenActualE), .BranchTargetE(BranchTargetE),
    .CorrectPredE(CorrectPredE), .RecoverE(RecoverE), .RecoverPCE(RecoverPCE)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    BranchE = 1'b1; BranchTakenActualE = taken; BranchTargetE = tgt;
  endtask

  task automatic idle_e();
    BranchE = 1'b0; BranchTakenActualE = 1'b0; BranchTargetE = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCF = 32'h40; StallD = 0; FlushD = 0; FlushE = 0; idle_e();
    step(); step();
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rst_pred got=%0h exp=0", PredTakenF); end
    checks++; if (CorrectPredE !== 1'b0) begin errors++; $display("FAIL rst_correct got=%0h exp=0", CorrectPredE); end
    checks++; if (RecoverE !== 1'b0) begin errors++; $display("FAIL rst_recover got=%0h exp=0", RecoverE); end
    checks++; if (RecoverPCE !== 32'h4) begin errors++; $display("FAIL rst_recpc got=%0h exp=4", RecoverPCE); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_cold_start();
    PCF = 32'h40; #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL cold_miss got=%0h exp=0", PredTakenF); end
    step(); step();  // 0x40 (not predicted) now in E
    resolve(1'b1, 32'h20); #1;
    checks++; if (CorrectPredE !== 1'b0 || RecoverE !== 1'b0) begin errors++; $display("FAIL cold_resolve got=%0h%0h exp=00", CorrectPredE, RecoverE); end
    // Same-index update in flight: lookup still sees the old (empty) entry.
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL collide_pre got=%0h exp=0", PredTakenF); end
    step(); idle_e(); #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alloc_pred got=%0h exp=1", PredTakenF); end
    checks++; if (PredTargetF !== 32'h20) begin errors++; $display("FAIL alloc_tgt got=%0h exp=20", PredTargetF); end
  endtask

  task automatic test_correct_pred();
    step(); step();  // predicted-taken 0x40 reaches E
    resolve(1'b1, 32'h20); #1;
    checks++; if (CorrectPredE !== 1'b1) begin errors++; $display("FAIL correct got=%0h exp=1", CorrectPredE); end
    checks++; if (RecoverE !== 1'b0) begin errors++; $display("FAIL correct_rec got=%0h exp=0", RecoverE); end
    step(); idle_e();  // ctr 2 -> 3
  endtask

  task automatic test_not_taken();
    step(); step();
    resolve(1'b0, 32'h0); #1;
    checks++; if (RecoverE !== 1'b1) begin errors++; $display("FAIL nt_recover got=%0h exp=1", RecoverE); end
    checks++; if (RecoverPCE !== 32'h44) begin errors++; $display("FAIL nt_recpc got=%0h exp=44", RecoverPCE); end
    checks++; if (CorrectPredE !== 1'b0) begin errors++; $display("FAIL nt_correct got=%0h exp=0", CorrectPredE); end
    step(); idle_e(); #1;  // ctr 3 -> 2, still taken
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL nt_ctr2 got=%0h exp=1", PredTakenF); end
    step(); step();
    resolve(1'b0, 32'h0); #1;
    checks++; if (RecoverE !== 1'b1) begin errors++; $display("FAIL nt2_recover got=%0h exp=1", RecoverE); end
    step(); idle_e(); #1;  // ctr 2 -> 1
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL nt_ctr1 got=%0h exp=0", PredTakenF); end
  endtask

  task automatic test_wrong_target();
    step(); step();
    resolve(1'b1, 32'h20); step(); idle_e(); #1;  // ctr 1 -> 2
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL wt_retrain got=%0h exp=1", PredTakenF); end
    step(); step();
    resolve(1'b1, 32'h80); #1;
    checks++; if (CorrectPredE !== 1'b0 || RecoverE !== 1'b0) begin errors++; $display("FAIL wt_resolve got=%0h%0h exp=00", CorrectPredE, RecoverE); end
    step(); idle_e(); #1;
    checks++; if (PredTargetF !== 32'h80) begin errors++; $display("FAIL wt_newtgt got=%0h exp=80", PredTargetF); end
  endtask

  task automatic test_stall();
    PCF = 32'h40; step();  // D = 0x40 predicted taken
    StallD = 1'b1; PCF = 32'h100;
    step(); step(); #1;
    checks++; if (RecoverPCE !== 32'h44) begin errors++; $display("FAIL stall_pc got=%0h exp=44", RecoverPCE); end
    checks++; if (RecoverE !== 1'b1) begin errors++; $display("FAIL stall_rec got=%0h exp=1", RecoverE); end
    StallD = 1'b0;
    step(); step(); #1;
    checks++; if (RecoverPCE !== 32'h104 || RecoverE !== 1'b0) begin errors++; $display("FAIL unstall got=%0h/%0h exp=104/0", RecoverPCE, RecoverE); end
  endtask

  task automatic test_flush_e();
    PCF = 32'h40; #1;
    // Prior cycles had RecoverE=1 with BranchE=0: entry must be untouched.
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin errors++; $display("FAIL nowrite got=%0h/%0h exp=1/80", PredTakenF, PredTargetF); end
    step(); step(); #1;
    checks++; if (RecoverE !== 1'b1) begin errors++; $display("FAIL flushe_pre got=%0h exp=1", RecoverE); end
    FlushE = 1'b1; step(); FlushE = 1'b0; #1;
    checks++; if (RecoverE !== 1'b0 || CorrectPredE !== 1'b0) begin errors++; $display("FAIL flushe got=%0h%0h exp=00", RecoverE, CorrectPredE); end
    checks++; if (RecoverPCE !== 32'h4) begin errors++; $display("FAIL flushe_pc got=%0h exp=4", RecoverPCE); end
  endtask

  task automatic test_flushd_stall();
    PCF = 32'h40; step();
    StallD = 1'b1; FlushD = 1'b1; step();
    FlushD = 1'b0; step(); #1;  // E picks up the held (cleared) D
    checks++; if (RecoverPCE !== 32'h4 || RecoverE !== 1'b0) begin errors++; $display("FAIL flushd got=%0h/%0h exp=4/0", RecoverPCE, RecoverE); end
    StallD = 1'b0;
  endtask

  task automatic test_alias();
    PCF = 32'h80; #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL alias_miss got=%0h exp=0", PredTakenF); end
    step(); step();
    // Flush in the same cycle must not cancel the update.
    resolve(1'b1, 32'h200); FlushE = 1'b1; step(); idle_e(); FlushE = 1'b0; #1;
    checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin errors++; $display("FAIL alias_alloc got=%0h/%0h exp=1/200", PredTakenF, PredTargetF); end
    PCF = 32'h40; #1;
    checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0) begin errors++; $display("FAIL alias_evict got=%0h/%0h exp=0/0", PredTakenF, PredTargetF); end
  endtask

  task automatic test_wrap();
    PCF = 32'hFFFF_FFFC; step(); step(); #1;
    checks++; if (RecoverPCE !== 32'h0) begin errors++; $display("FAIL wrap got=%0h exp=0", RecoverPCE); end
  endtask

  task automatic test_reset_mid();
    PCF = 32'h80; step(); step(); #1;
    checks++; if (PredTakenF !== 1'b1 || RecoverE !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0h%0h exp=11", PredTakenF, RecoverE); end
    #2 reset = 1'b0; #1;
    checks++; if (PredTakenF !== 1'b0 || RecoverE !== 1'b0 || RecoverPCE !== 32'h4) begin errors++; $display("FAIL mid_async got=%0h/%0h/%0h exp=0/0/4", PredTakenF, RecoverE, RecoverPCE); end
    #2 reset = 1'b1;
    step(); #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL mid_cold got=%0h exp=0", PredTakenF); end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_correct_pred();
    test_not_taken();
    test_wrong_target();
    test_stall();
    test_flush_e();
    test_flushd_stall();
    test_alias();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
